// File: rtl/btb_pkg.sv
// Shared types and constants for the branch target buffer.
package btb_pkg;
    localparam int ENTRIES_DEF = 8;
    localparam int IDX_W_DEF   = $clog2(ENTRIES_DEF);

    typedef logic [1:0] ctr_t;
    localparam ctr_t CTR_INIT = 2'b10;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken);
        if (taken) return (c == 2'b11) ? c : c + 2'b01;
        else       return (c == 2'b00) ? c : c - 2'b01;
    endfunction
endpackage

// File: rtl/btb_array_cell.sv
// Address/target store for one BTB entry; unreset, masked by the entry valid bit.
module BTB_cell (
    input  logic        clk,
    input  logic        update,
    input  logic [31:0] pc_in,
    input  logic [31:0] target_in,
    output logic [31:0] pc,
    output logic [31:0] target
);
    // Capture address and target only when this entry is written.
    always_ff @(posedge clk) begin
        if (update) begin
            pc     <= pc_in;
            target <= target_in;
        end
    end
endmodule

// File: rtl/btb_array.sv
// Fully-associative BTB with 2-bit direction counters and round-robin replacement.
module btb_array
    import btb_pkg::*;
#(
    parameter int ENTRIES = ENTRIES_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [31:0] lookup_pc,
    output logic        hit,
    output logic        predict_taken,
    output logic [31:0] predict_target,
    input  logic        update_valid,
    input  logic [31:0] update_pc,
    input  logic [31:0] update_target,
    input  logic        update_taken
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [ENTRIES-1:0]        valid;
    ctr_t                      ctr [ENTRIES];
    logic [IDX_W-1:0]          ptr;
    logic                      upd_en;   // low for the first edge after reset release
    logic [ENTRIES-1:0][31:0]  pc_q;
    logic [ENTRIES-1:0][31:0]  tgt_q;
    logic [ENTRIES-1:0]        we;

    logic                      l_hit, u_hit, all_valid;
    logic [IDX_W-1:0]          l_idx, u_idx, a_idx;

    for (genvar i = 0; i < ENTRIES; i++) begin : g_cell
        BTB_cell u_cell (
            .clk       (clk),
            .update    (we[i]),
            .pc_in     (update_pc),
            .target_in (update_target),
            .pc        (pc_q[i]),
            .target    (tgt_q[i])
        );
    end

    // Match search: scan high to low so the lowest index wins; also pick alloc slot.
    always_comb begin
        l_hit     = 1'b0;
        l_idx     = '0;
        u_hit     = 1'b0;
        u_idx     = '0;
        a_idx     = ptr;
        all_valid = &valid;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid[i] && pc_q[i] == lookup_pc) begin
                l_hit = 1'b1;
                l_idx = IDX_W'(i);
            end
            if (valid[i] && pc_q[i] == update_pc) begin
                u_hit = 1'b1;
                u_idx = IDX_W'(i);
            end
            if (!valid[i]) a_idx = IDX_W'(i);
        end
    end

    assign hit            = l_hit & ~rst;
    assign predict_taken  = hit & ctr[l_idx][1];
    assign predict_target = hit ? tgt_q[l_idx] : 32'h0;

    // Storage write enable: taken hit rewrites target, taken miss allocates.
    always_comb begin
        we = '0;
        if (upd_en && !rst && !flush && update_valid && update_taken)
            we[u_hit ? u_idx : a_idx] = 1'b1;
    end

    // Valid bits, counters and replacement pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid  <= '0;
            ptr    <= '0;
            upd_en <= 1'b0;
            for (int i = 0; i < ENTRIES; i++) ctr[i] <= 2'b00;
        end else begin
            upd_en <= 1'b1;
            if (flush) begin
                valid <= '0;
                ptr   <= '0;
            end else if (update_valid && upd_en) begin
                if (u_hit) begin
                    ctr[u_idx] <= ctr_next(ctr[u_idx], update_taken);
                end else if (update_taken) begin
                    valid[a_idx] <= 1'b1;
                    ctr[a_idx]   <= CTR_INIT;
                    if (all_valid) ptr <= ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_btb_array.sv
// Directed vector bench for btb_array.
module tb_btb_array;
    logic        clk = 1'b0;
    logic        rst, flush;
    logic [31:0] lookup_pc;
    logic        hit, predict_taken;
    logic [31:0] predict_target;
    logic        update_valid;
    logic [31:0] update_pc, update_target;
    logic        update_taken;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    btb_array #(.ENTRIES(8)) dut (
        .clk(clk), .rst(rst), .flush(flush), .lookup_pc(lookup_pc),
        .hit(hit), .predict_taken(predict_taken), .predict_target(predict_target),
        .update_valid(update_valid), .update_pc(update_pc),
        .update_target(update_target), .update_taken(update_taken)
    );

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic [31:0] lpc;
        logic        e_hit;
        logic        e_tk;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_look(input string name, input logic eh, input logic et, input logic [31:0] eg);
        check({name, ".hit"}, {31'd0, hit}, {31'd0, eh});
        check({name, ".taken"}, {31'd0, predict_taken}, {31'd0, et});
        check({name, ".target"}, predict_target, eg);
    endtask

    // Drive a cycle's inputs just after the falling edge.
    task automatic drive(input logic uv, input logic [31:0] upc, input logic [31:0] utgt,
                         input logic utk, input logic fl, input logic [31:0] lpc);
        @(negedge clk);
        update_valid  = uv;
        update_pc     = upc;
        update_target = utgt;
        update_taken  = utk;
        flush         = fl;
        lookup_pc     = lpc;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; lookup_pc = 32'h100;
        update_valid = 1'b0; update_pc = '0; update_target = '0; update_taken = 1'b0;
        //          uv   upc      utgt     utk   lpc      hit  tk   tgt
        vecs[0]  = '{1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 32'h100, 32'h200, 1'b1, 32'h100, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[3]  = '{1'b1, 32'h100, 32'h999, 1'b0, 32'h100, 1'b1, 1'b1, 32'h200};
        vecs[4]  = '{1'b1, 32'h100, 32'h999, 1'b0, 32'h100, 1'b1, 1'b0, 32'h200};
        vecs[5]  = '{1'b1, 32'h100, 32'h204, 1'b1, 32'h100, 1'b1, 1'b0, 32'h200};
        vecs[6]  = '{1'b1, 32'h100, 32'h204, 1'b1, 32'h100, 1'b1, 1'b0, 32'h204};
        vecs[7]  = '{1'b1, 32'h100, 32'h204, 1'b1, 32'h100, 1'b1, 1'b1, 32'h204};
        vecs[8]  = '{1'b1, 32'h100, 32'h204, 1'b1, 32'h100, 1'b1, 1'b1, 32'h204};
        vecs[9]  = '{1'b1, 32'h500, 32'h600, 1'b0, 32'h100, 1'b1, 1'b1, 32'h204};
        vecs[10] = '{1'b0, 32'h0,   32'h0,   1'b0, 32'h500, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 32'h0,   32'h0,   1'b0, 32'h100, 1'b1, 1'b1, 32'h204};

        #12;
        check_look("in_reset", 1'b0, 1'b0, 32'h0);
        check("rst_ptr", 32'(dut.ptr), 32'd0);
        check("rst_ctr0", 32'(dut.ctr[0]), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);   // first edge after release: updates ignored

        foreach (vecs[i]) begin
            drive(vecs[i].uv, vecs[i].upc, vecs[i].utgt, vecs[i].utk, 1'b0, vecs[i].lpc);
            check_look($sformatf("vec%0d", i), vecs[i].e_hit, vecs[i].e_tk, vecs[i].e_tgt);
            if (i == 2) check("ctr_after_alloc", 32'(dut.ctr[0]), 32'h2);
            if (i == 5) check("ctr_after_2nt", 32'(dut.ctr[0]), 32'h0);
        end
        check("ctr_saturated", 32'(dut.ctr[0]), 32'h3);

        // Reset with valid content: outputs masked, update on release edge dropped.
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h100);
        rst = 1'b1; #1;
        check_look("rst_mask", 1'b0, 1'b0, 32'h0);
        drive(1'b1, 32'h700, 32'h800, 1'b1, 1'b0, 32'h700);
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h700);
        check_look("rst_release_upd", 1'b0, 1'b0, 32'h0);

        // Fill all 8 entries then one more: the 9th evicts entry 0.
        for (int k = 0; k < 9; k++)
            drive(1'b1, 32'h1000 + 32'(4 * k), 32'h2000 + 32'(k), 1'b1, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1000);
        check_look("evicted_first", 1'b0, 1'b0, 32'h0);
        check("ptr_after_evict", 32'(dut.ptr), 32'd1);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1020);
        check_look("ninth_pc", 1'b1, 1'b1, 32'h2008);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1004);
        check_look("second_pc", 1'b1, 1'b1, 32'h2001);

        // Flush wins over a coincident taken update.
        drive(1'b1, 32'h300, 32'h400, 1'b1, 1'b1, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h300);
        check_look("flush_upd", 1'b0, 1'b0, 32'h0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h1004);
        check_look("flush_old", 1'b0, 1'b0, 32'h0);
        check("ptr_after_flush", 32'(dut.ptr), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
